// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC -> variable-latency IMEM handshake -> IF/ID register.
// Optional IF_FETCH_STATS_EN adds stall-cycle and flush counters.
module if_fetch_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        id_stall,
    input  logic        id_flush,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
`ifdef IF_FETCH_STATS_EN
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_flush_count,
`endif
    output logic        if_id_valid
);

    typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] pc_next;

    assign pc_next     = pc_in + PC_STEP;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

    // FULL issues no request, so the last captured address is presented there too.
    assign imem_addr = (state_q == S_FETCH) ? pc_in : addr_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        pc_hold      = 1'b0;
        imem_req     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    addr_d   = pc_in;
                    if (id_flush) begin
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                        if (!imem_valid) state_d = S_DRAIN;
                    end else if (id_stall) begin
                        pc_hold = 1'b1;
                        if (imem_valid) begin
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = pc_next;
                            state_d      = S_FULL;
                        end
                    end else if (imem_valid) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_next;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                        pc_hold = 1'b1;
                    end
                end
                S_FULL: begin
                    if (id_flush) begin
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                        state_d = S_FETCH;
                    end else if (id_stall) begin
                        pc_hold = 1'b1;
                    end else begin
                        instr_d = skid_instr_q;
                        pc4_d   = skid_pc4_q;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // The outstanding response belongs to the squashed path and is dropped.
                    imem_req = 1'b1;
                    pc_hold  = 1'b1;
                    if (id_flush) begin
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                    end else begin
                        if (!id_stall) begin
                            valid_d = 1'b0;
                            instr_d = NOP_WORD;
                        end
                        if (imem_valid) state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            addr_q       <= '0;
            instr_q      <= NOP_WORD;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

`ifdef IF_FETCH_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
    assign stat_flush_count  = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold)  stall_cnt_q <= stall_cnt_q + 32'd1;
            if (id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly downstream of the program counter. Takes the current PC, runs a request/valid handshake with a variable-latency instruction memory, and loads the IF/ID pipeline register (instruction, PC+4, valid). Generates the hold signal back to the program counter and handles decode stalls and branch/jump flushes, including discarding in-flight fetches.

Parameters:
NOP_WORD, 32'h00000000, instruction word loaded into the IF/ID register for a bubble
PC_STEP, 4, increment added to the fetch address to form PC+4

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high
pc_in  input  32  current PC from the program counter
pc_hold  output  1  to PC hold input; 1 = PC must not advance
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; stable while a request is outstanding
imem_rdata  input  32  instruction word; valid when imem_valid=1
imem_valid  input  1  response strobe; may assert in the same cycle as imem_req (zero-wait)
id_stall  input  1  decode hazard stall; IF/ID must hold
id_flush  input  1  branch/jump taken; squash fetched instruction, PC loads target
if_id_instr  output  32  registered instruction to decode
if_id_pc4  output  32  registered fetch address + PC_STEP
if_id_valid  output  1  registered; 0 = bubble

Behaviour:
- Reset (sync, active-high): state<=FETCH, if_id_instr<=NOP_WORD, if_id_pc4<=0, if_id_valid<=0, skid register and addr_q cleared. While reset=1: imem_req=0, pc_hold=0.
- The instruction memory shares the same reset. No response is expected after reset deasserts for a request issued before it.
- imem_valid is ignored whenever imem_req=0.
- addr_q captures pc_in each FETCH cycle. imem_addr = pc_in in FETCH, addr_q in DRAIN.
- Priority in every state: reset > id_flush > id_stall > imem_valid.
- "Bubble" means if_id_valid<=0 and if_id_instr<=NOP_WORD, with if_id_pc4 unchanged.
- FETCH (imem_req=1):
  - id_flush: load bubble; pc_hold=0. If imem_valid=1, drop the response and stay in FETCH. If imem_valid=0, go to DRAIN.
  - id_stall: IF/ID holds. If imem_valid=1, capture imem_rdata and pc_in+PC_STEP into the skid register and go to FULL. pc_hold=1.
  - imem_valid=1 (no flush, no stall): if_id_instr<=imem_rdata, if_id_pc4<=pc_in+PC_STEP, if_id_valid<=1; pc_hold=0. Zero-wait memory therefore sustains 1 instruction/cycle.
  - imem_valid=0 (no flush, no stall): load bubble; pc_hold=1.
- FULL (imem_req=0, response held in skid):
  - id_flush: discard skid, load bubble, pc_hold=0, go to FETCH.
  - id_stall: IF/ID and skid hold; pc_hold=1.
  - otherwise: skid moves to IF/ID with valid=1, pc_hold=0, go to FETCH.
- DRAIN (imem_req=1, addr=addr_q, pc_hold=1; PC already loaded the target on the flush cycle):
  - imem_valid=1: discard the response, go to FETCH.
  - IF/ID holds if id_stall=1, otherwise loads a bubble.
  - A repeated id_flush keeps the state in DRAIN.
- Arithmetic: pc_in+PC_STEP is modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- pc_hold is combinational from state and inputs. The PC samples it on the falling edge, half a cycle after this block's inputs settle.
- Reset in any state aborts the operation immediately. The skid contents and any pending discard are lost.

Optional Feature:
Macro IF_FETCH_STATS_EN.
- Defined: adds outputs stat_stall_cycles[31:0] (counts cycles with pc_hold=1 and reset=0) and stat_flush_count[31:0] (counts cycles with id_flush=1 in any state). Both are synchronously reset to 0 and wrap at 2^32.
- Undefined: neither port nor the counter logic exists, and all other behaviour is identical.

Test Plan:
1. Zero-wait memory, reset then pc_in=0, rdata=0x20080005 with imem_valid=1 -> next edge: if_id_instr=0x20080005, if_id_pc4=0x4, if_id_valid=1; pc_hold=0 throughout.
2. Two-wait-state memory at pc_in=0x40 -> pc_hold=1 and if_id_valid=0 for 2 cycles, then if_id_instr=rdata, if_id_pc4=0x44, valid=1.
3. id_stall=1 in the response cycle (rdata=0x8C090000), held for 3 cycles -> state FULL, pc_hold=1, imem_req=0, IF/ID unchanged. After release -> if_id_instr=0x8C090000, valid=1.
4. id_flush=1 while waiting (no imem_valid), then a late response 0xDEADBEEF -> pc_hold=0 on the flush cycle, DRAIN, and 0xDEADBEEF never appears with if_id_valid=1. The next fetch uses the new pc_in.
5. In FULL, id_flush=1 and id_stall=1 together -> bubble (valid=0, instr=NOP_WORD), state FETCH, pc_hold=0.
6. pc_in=0xFFFFFFFC fetched -> if_id_pc4=0x00000000. Separately, reset asserted mid-wait -> all outputs at reset values on the next edge.
